// File: rtl/sorted_array_search_if.sv
// sorted_array_search_if: array/key request and search result bundle; SEARCH_SORTED_CHECK_EN adds unsorted.
interface sorted_array_search_if #(parameter int word_size = 4, parameter int idx_size = 4);
  logic [word_size-1:0] A1, A2, A3, A4, A5, A6, A7, A8, key;
  logic start, busy, done, found;
  logic [idx_size-1:0] index, lower_bound;
`ifdef SEARCH_SORTED_CHECK_EN
  logic unsorted;
`endif
  modport master(
    output A1, A2, A3, A4, A5, A6, A7, A8, key, start,
    input busy, done, found, index, lower_bound
`ifdef SEARCH_SORTED_CHECK_EN
    , input unsorted
`endif
  );
  modport slave(
    input A1, A2, A3, A4, A5, A6, A7, A8, key, start,
    output busy, done, found, index, lower_bound
`ifdef SEARCH_SORTED_CHECK_EN
    , output unsorted
`endif
  );
endinterface

// File: rtl/sorted_array_search.sv
// sorted_array_search: fixed-latency lower-bound binary search over a captured 8-word array; SEARCH_SORTED_CHECK_EN adds unsorted detection.
module sorted_array_search #(
  parameter int N = 8,
  parameter int word_size = 4,
  parameter int idx_size = 4,
  parameter int PROBES = 4
) (
  input logic clk,
  input logic rst,
  sorted_array_search_if.slave sif
);
  localparam int CW = $clog2(PROBES);
  typedef enum logic [1:0] {S_idle, S_search, S_done} state_t;
  state_t state, state_nxt;
  logic [word_size-1:0] cap [1:N];
  logic [word_size-1:0] key_q, cap_mid, cap_lo;
  logic [idx_size-1:0] lo, hi, mid, lo_nxt, hi_nxt, lb_q, index_q;
  logic [CW-1:0] cnt;
  logic found_q, last, go_left, hit, ok;
  assign mid = idx_size'(({1'b0, lo} + {1'b0, hi}) >> 1);
  always_comb begin
    cap_mid = '0;
    for (int k = 1; k <= N; k++) cap_mid = (mid == idx_size'(k)) ? cap[k] : cap_mid;
  end
  assign go_left = (lo < hi) && (cap_mid < key_q);
  assign lo_nxt = go_left ? mid + idx_size'(1) : lo;
  assign hi_nxt = (lo < hi) && !go_left ? mid : hi;
  always_comb begin
    cap_lo = '0;
    for (int k = 1; k <= N; k++) cap_lo = (lo_nxt == idx_size'(k)) ? cap[k] : cap_lo;
  end
  assign hit = (lo_nxt <= idx_size'(N)) && (cap_lo == key_q);
  assign last = cnt == CW'(PROBES - 1);
`ifdef SEARCH_SORTED_CHECK_EN
  logic uns_c, uns_q;
  always_comb begin
    uns_c = 1'b0;
    for (int k = 2; k <= N; k++) uns_c = uns_c | (cap[k-1] > cap[k]);
  end
  assign ok = hit && !uns_c;
  assign sif.unsorted = uns_q;
  always_ff @(posedge clk)
    if (!rst) uns_q <= 1'b0;
    else if (state == S_search && last) uns_q <= uns_c;
`else
  assign ok = hit;
`endif
  always_comb begin
    state_nxt = state == S_idle ? (sif.start ? S_search : S_idle) :
                state == S_search ? (last ? S_done : S_search) : S_idle;
  end
  always_ff @(posedge clk) state <= !rst ? S_idle : state_nxt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= N; k++) cap[k] <= '0;
      key_q <= '0;
      lo <= '0;
      hi <= '0;
      cnt <= '0;
      found_q <= 1'b0;
      index_q <= '0;
      lb_q <= '0;
    end else if (state == S_idle && sif.start) begin
      cap[1] <= sif.A1;
      cap[2] <= sif.A2;
      cap[3] <= sif.A3;
      cap[4] <= sif.A4;
      cap[5] <= sif.A5;
      cap[6] <= sif.A6;
      cap[7] <= sif.A7;
      cap[8] <= sif.A8;
      key_q <= sif.key;
      lo <= idx_size'(1);
      hi <= idx_size'(N + 1);
      cnt <= '0;
    end else if (state == S_search) begin
      lo <= lo_nxt;
      hi <= hi_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        lb_q <= lo_nxt;
        found_q <= ok;
        index_q <= ok ? lo_nxt : '0;
      end
    end
  end
  assign sif.busy = state != S_idle;
  assign sif.done = state == S_done;
  assign sif.found = found_q;
  assign sif.index = index_q;
  assign sif.lower_bound = lb_q;
endmodule

// File: tb/tb_sorted_array_search.sv
// tb_sorted_array_search: directed scoreboard bench for sorted_array_search (honours SEARCH_SORTED_CHECK_EN).
module tb_sorted_array_search;
  typedef logic [3:0] arr_t [8];
  typedef struct {
    logic [3:0] lb;
    logic [3:0] idx;
    logic f;
    logic u;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  sorted_array_search_if bus();
  sorted_array_search dut(.clk(clk), .rst(rst), .sif(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_arr(input arr_t a, input logic [3:0] k);
    bus.A1 = a[0]; bus.A2 = a[1]; bus.A3 = a[2]; bus.A4 = a[3];
    bus.A5 = a[4]; bus.A6 = a[5]; bus.A7 = a[6]; bus.A8 = a[7];
    bus.key = k;
  endtask
  // Linear scan reference; lb_ovr replaces lb when the array is deliberately unsorted.
  function automatic exp_t model(input arr_t a, input logic [3:0] k, input int lb_ovr);
    exp_t e;
    int p = 9;
    for (int i = 7; i >= 0; i--) if (a[i] >= k) p = i + 1;
    e.u = 1'b0;
    for (int i = 1; i < 8; i++) if (a[i-1] > a[i]) e.u = 1'b1;
    if (lb_ovr > 0) p = lb_ovr;
    e.lb = 4'(p);
    e.f = (p <= 8) && (a[p-1] == k) && !e.u;
    e.idx = e.f ? 4'(p) : 4'd0;
    return e;
  endfunction
  task automatic search(input string tag, input arr_t a, input logic [3:0] k, input bit hold, input bit mutate, input int lb_ovr);
    exp_t e;
    arr_t z = '{default: 4'd0};
    int n, bc;
    set_arr(a, k);
    bus.start = 1'b1;
    q.push_back(model(a, k, lb_ovr));
    step();
    bus.start = hold;
    if (mutate) set_arr(z, 4'd15);
    bc = 0;
    for (n = 0; n < 20; n++) begin
      if (bus.busy) bc++;
      if (bus.done) break;
      step();
    end
    chk({tag, "_done_seen"}, n < 20, 1);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_busy_cycles"}, bc, 5);
    e = q.pop_front();
    chk({tag, "_lower_bound"}, bus.lower_bound, e.lb);
    chk({tag, "_found"}, bus.found, e.f);
    chk({tag, "_index"}, bus.index, e.idx);
`ifdef SEARCH_SORTED_CHECK_EN
    chk({tag, "_unsorted"}, bus.unsorted, e.u);
`endif
    step();
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) n++;
      step();
    end
    chk({tag, "_no_extra_done"}, n, 0);
    chk({tag, "_held_lb"}, bus.lower_bound, e.lb);
  endtask
  initial begin
    arr_t a18 = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8};
    arr_t a5 = '{default: 4'd5};
    arr_t aseq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    int n;
    bus.start = 1'b0;
    set_arr(a18, 4'd0);
    rst = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_index", bus.index, 0);
    chk("rst_lb", bus.lower_bound, 0);
`ifdef SEARCH_SORTED_CHECK_EN
    chk("rst_unsorted", bus.unsorted, 0);
`endif
    rst = 1'b1;
    step();
    search("k8", a18, 4'd8, 0, 0, 0);
    search("k5", a18, 4'd5, 0, 0, 0);
    search("k0", a18, 4'd0, 0, 0, 0);
    search("k9", a18, 4'd9, 0, 0, 0);
    search("all5", a5, 4'd5, 0, 0, 0);
    search("seq7", aseq, 4'd7, 0, 0, 0);
    search("seq1", aseq, 4'd1, 0, 0, 0);
    search("seq15", aseq, 4'd15, 0, 0, 0);
    search("hold_mut", a18, 4'd8, 1, 1, 0);
    // Abort during the second search cycle.
    search("pre_abort", aseq, 4'd3, 0, 0, 0);
    set_arr(a18, 4'd8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_found", bus.found, 0);
    chk("abort_index", bus.index, 0);
    chk("abort_lb", bus.lower_bound, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) n++;
      step();
    end
    chk("abort_no_done", n, 0);
    search("after_abort", a18, 4'd8, 0, 0, 0);
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    rst = 1'b1;
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done || bus.busy) n++;
      step();
    end
    chk("rst_start_idle", n, 0);
`ifdef SEARCH_SORTED_CHECK_EN
    begin
      arr_t alt = '{4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1};
      search("unsorted", alt, 4'd8, 0, 0, 3);
      search("sorted_again", aseq, 4'd4, 0, 0, 0);
    end
`endif
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
